// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg: shared definitions for the vector_checker response checker.
// Contents:
//   state_t      - run-control FSM encoding (idle, run, drain, done)
//   LATENCY_MAX  - largest supported DUT latency
//   INDEX_NONE   - "no failure recorded" marker; slice to the counter width
package vector_checker_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

    localparam int unsigned LATENCY_MAX = 15;
    localparam logic [63:0] INDEX_NONE  = '1;

endpackage

// File: rtl/check_log_fifo.sv
// check_log_fifo: small synchronous FIFO that drops pushes when full.
// A push and a pop in the same cycle are both accepted, even when full.
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   clear            - synchronous flush of contents and overflow flag
//   push, push_data  - write request and data
//   pop              - read request (ignored when empty)
//   valid, pop_data  - head entry present / head entry
//   full             - no free slot
//   overflow         - sticky: a push was dropped
module check_log_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign valid    = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && valid;
    assign do_push  = push && (!full || do_pop);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vector_checker.sv
// vector_checker: aligns expected vectors to a fixed-latency DUT and compares them
// channel by channel under a per-bit mask, keeping run statistics.
// Optional failure log: define CHECK_LOG_EN to add a FIFO of {index, ch_fail}.
// Ports:
//   clock, reset_n          - rising-edge clock, asynchronous active-low reset
//   start, stop_on_error    - begin a run (idle/done only); halt after first mismatch
//   stim_valid/ready/last   - expected-vector handshake, last marks end of run
//   exp_data, exp_mask      - expected outputs and compare enables, channel c at [c*WIDTH +: WIDTH]
//   dut_data                - DUT outputs, LATENCY cycles after acceptance
//   done, error             - run complete; sticky mismatch seen
//   fail_channels           - sticky per-channel mismatch flags
//   vector_count, error_count, first_fail_index - saturating statistics
//   log_* (CHECK_LOG_EN)    - failure log pop interface and sticky overflow
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       stop_on_error,
    input  logic                       stim_valid,
    output logic                       stim_ready,
    input  logic                       stim_last,
    input  logic [CHANNELS*WIDTH-1:0]  exp_data,
    input  logic [CHANNELS*WIDTH-1:0]  exp_mask,
    input  logic [CHANNELS*WIDTH-1:0]  dut_data,
    output logic                       done,
    output logic                       error,
    output logic [CHANNELS-1:0]        fail_channels,
    output logic [CNT_W-1:0]           vector_count,
    output logic [CNT_W-1:0]           error_count,
    output logic [CNT_W-1:0]           first_fail_index
`ifdef CHECK_LOG_EN
    ,
    output logic                       log_valid,
    input  logic                       log_ready,
    output logic [CNT_W-1:0]           log_index,
    output logic [CHANNELS-1:0]        log_channels,
    output logic                       log_overflow
`endif
);

    localparam int unsigned     VW       = CHANNELS * WIDTH;
    localparam logic [CNT_W-1:0] IDX_NONE = INDEX_NONE[CNT_W-1:0];

    typedef struct packed {
        logic             valid;
        logic             last;
        logic [CNT_W-1:0] index;
        logic [VW-1:0]    data;
        logic [VW-1:0]    mask;
    } entry_t;

    state_t              state;
    logic                stop_en;
    logic [CNT_W-1:0]    next_index;
    logic                accept;
    logic                start_run;
    entry_t              in_entry;
    entry_t              cmp_entry;
    logic [CHANNELS-1:0] ch_fail;
    logic                cmp_fail;
    logic                line_busy;

    assign accept    = stim_valid && stim_ready;
    assign start_run = start && ((state == StIdle) || (state == StDone));

    always_comb begin
        in_entry       = '0;
        in_entry.valid = accept;
        in_entry.last  = stim_last;
        in_entry.index = next_index;
        in_entry.data  = exp_data;
        in_entry.mask  = exp_mask;
    end

    if (LATENCY == 0) begin : g_direct
        // Compare on the accept cycle; ready cannot depend on the compare here.
        assign cmp_entry  = in_entry;
        assign line_busy  = 1'b0;
        assign stim_ready = (state == StRun);
    end else begin : g_line
        entry_t pipe [LATENCY];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < LATENCY; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= in_entry;
                for (int unsigned i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            end
        end

        always_comb begin
            line_busy = 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) line_busy = line_busy | pipe[i].valid;
        end

        assign cmp_entry  = pipe[LATENCY-1];
        // Drop ready in the mismatch cycle itself so no beat is accepted after the failure.
        assign stim_ready = (state == StRun) && !(stop_en && cmp_fail);
    end

    always_comb begin
        ch_fail = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            ch_fail[c] = cmp_entry.valid &
                (|((dut_data[c*WIDTH +: WIDTH] ^ cmp_entry.data[c*WIDTH +: WIDTH]) &
                   cmp_entry.mask[c*WIDTH +: WIDTH]));
        end
    end
    assign cmp_fail = |ch_fail;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= StIdle;
            done             <= 1'b0;
            stop_en          <= 1'b0;
            next_index       <= '0;
            error            <= 1'b0;
            fail_channels    <= '0;
            vector_count     <= '0;
            error_count      <= '0;
            first_fail_index <= IDX_NONE;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state   <= StRun;
                        done    <= 1'b0;
                        stop_en <= stop_on_error;
                    end
                end
                StRun: begin
                    if ((accept && stim_last) || (stop_en && cmp_fail)) state <= StDrain;
                end
                StDrain: begin
                    if (!line_busy) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase

            if (start_run) begin
                next_index       <= '0;
                error            <= 1'b0;
                fail_channels    <= '0;
                vector_count     <= '0;
                error_count      <= '0;
                first_fail_index <= IDX_NONE;
            end else begin
                if (accept && (next_index != IDX_NONE)) next_index <= next_index + 1'b1;
                if (cmp_entry.valid && (vector_count != '1)) begin
                    vector_count <= vector_count + 1'b1;
                end
                if (cmp_fail) begin
                    error         <= 1'b1;
                    fail_channels <= fail_channels | ch_fail;
                    if (error_count != '1) error_count <= error_count + 1'b1;
                    if (first_fail_index == IDX_NONE) first_fail_index <= cmp_entry.index;
                end
            end
        end
    end

`ifdef CHECK_LOG_EN
    logic log_full;

    check_log_fifo #(
        .WIDTH(CNT_W + CHANNELS),
        .DEPTH(LOG_DEPTH)
    ) u_log (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (start_run),
        .push     (cmp_fail),
        .push_data({cmp_entry.index, ch_fail}),
        .pop      (log_ready),
        .valid    (log_valid),
        .pop_data ({log_index, log_channels}),
        .full     (log_full),
        .overflow (log_overflow)
    );

    logic unused_bits;
    assign unused_bits = cmp_entry.last ^ log_full;
`else
    logic unused_bits;
    assign unused_bits = cmp_entry.last ^ (^LOG_DEPTH);
`endif

endmodule

// File: doc/vector_checker.md
Name: vector_checker

Overview:
- Synthesizable, parametrised response checker for the team's HDL verification flow.
- Takes a stream of expected vectors with per-bit compare masks, aligns them to a DUT with fixed pipeline latency, and compares them against the DUT outputs on every channel.
- Counts vectors and mismatches, keeps sticky per-channel failure flags, records the first failing vector index, and can halt on the first error.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of compared channels.
- LATENCY, 1, DUT latency in cycles, legal range 0..15.
- CNT_W, 16, width of the vector, error and index counters.
- LOG_DEPTH, 4, failure-log entries (used only with CHECK_LOG_EN).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run, clearing all statistics; honoured only in IDLE or DONE.
- stop_on_error  in  1  halt input acceptance after the first mismatch; sampled at start.
- stim_valid  in  1  expected vector valid.
- stim_ready  out  1  checker accepts a vector.
- stim_last  in  1  marks the final vector of the run.
- exp_data  in  CHANNELS*WIDTH  expected DUT outputs; channel c occupies bits [c*WIDTH +: WIDTH].
- exp_mask  in  CHANNELS*WIDTH  per-bit compare enable (1 = compare, 0 = don't-care).
- dut_data  in  CHANNELS*WIDTH  DUT outputs, sampled LATENCY cycles after the vector was accepted.
- done  out  1  run complete.
- error  out  1  sticky: at least one mismatch this run.
- fail_channels  out  CHANNELS  sticky per-channel mismatch flags.
- vector_count  out  CNT_W  vectors compared.
- error_count  out  CNT_W  mismatching vectors.
- first_fail_index  out  CNT_W  index (0-based) of the first mismatching vector.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. stim_ready = 0, done = 0, error = 0, fail_channels = 0, all counts = 0, first_fail_index = all-ones, delay line cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start → RUN. Counters, flags and first_fail_index are cleared on that edge; done drops.
  - RUN: stim_ready = 1. An accepted beat (valid & ready) pushes {exp_data, exp_mask, last, index} into a LATENCY-deep shift line. A cycle with no accepted beat pushes a bubble.
  - RUN → DRAIN when a last beat is accepted, or (stop_on_error && first mismatch detected).
  - DRAIN: stim_ready = 0. Moves to DONE the cycle after the delay line holds no valid entries.
  - DONE: done = 1, stim_ready = 0, all statistics held.
  - start while in RUN or DRAIN is ignored.
- Compare stage:
  - Applies to each valid entry leaving the delay line: ch_fail[c] = |((dut_data ^ exp) & mask) over channel c.
  - vector_count increments on every compared entry.
  - If any ch_fail bit is set: error_count increments, error is set, fail_channels |= ch_fail, and first_fail_index captures the entry's index if still all-ones.
- LATENCY = 0: the compare happens on the accept cycle itself, and DRAIN lasts 1 cycle.
- Vectors already in flight when stop_on_error triggers are still compared and counted.
- All counters saturate at all-ones; the index counter also saturates.
- The stim_last beat is always compared before done asserts.
- A fully masked vector (mask = 0) counts as a vector and never fails.

Optional Feature:
- Macro: CHECK_LOG_EN.
- Defined:
  - Adds a LOG_DEPTH-entry FIFO of {index, ch_fail}, pushed on every mismatch.
  - Adds ports log_valid out 1, log_ready in 1, log_index out CNT_W, log_channels out CHANNELS, log_overflow out 1 (sticky).
  - Entries are popped on log_valid & log_ready. A push when the FIFO is full drops the new entry and sets log_overflow.
  - Simultaneous push and pop when full are both accepted.
  - The FIFO and log_overflow are cleared by start and by reset.
- Undefined: none of these ports or this storage exist; behaviour is otherwise identical.

Decomposition:
- Package vector_checker_pkg: FSM state encoding (IDLE, RUN, DRAIN, DONE), LATENCY_MAX = 15, INDEX_NONE = all-ones.
- Sub-module check_log_fifo: parametrised synchronous FIFO with full/empty and drop-on-full, instantiated only under CHECK_LOG_EN.

Test Plan:
1. LATENCY = 1, CHANNELS = 4, WIDTH = 8: 5 vectors with dut_data = exp_data, last on vector 4 → done = 1, vector_count = 5, error_count = 0, error = 0, first_fail_index = 0xFFFF.
2. Vector 2 channel 1 is off by bit 3 (mask all-ones) → error = 1, error_count = 1, fail_channels = 4'b0010, first_fail_index = 2.
3. Same stimulus with the channel-1 mask = 8'hF7 → no error, error_count = 0.
4. stop_on_error = 1, LATENCY = 3, mismatch on vector 1 of 10 → stim_ready falls, done asserts, vector_count = 4 (vectors 0..3 in flight are compared), first_fail_index = 1.
5. Assert reset_n low mid-RUN with error set → all outputs return to reset values immediately (asynchronously); a fresh start then gives clean counts.
6. CHECK_LOG_EN, LOG_DEPTH = 4, 6 failing vectors, log_ready = 0 → 4 entries held with indices 0..3, log_overflow = 1; popping returns them in order.
